// File: rtl/rmii_tx.sv
// RMII transmit serialiser: preamble/SFD, LSB-dibit-first payload, optional
// CRC-32 FCS, then a fixed inter-packet gap. All outputs are registered.
module rmii_tx #(
    parameter int unsigned PREAMBLE_BYTES = 7,
    parameter int unsigned IPG_CYCLES     = 48,
    parameter int unsigned FCS_EN         = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       axiiv,
    input  logic [7:0] axiid,
    input  logic       axiil,
    output logic       axiir,
    output logic       txen,
    output logic [1:0] txd
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [15:0] PRE_LAST = 16'(4 * PREAMBLE_BYTES + 3);
    localparam logic [15:0] IPG_LAST = 16'(IPG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_PAY,
        S_FCS,
        S_IPG
    } state_t;

    state_t      r_state, w_state;
    logic [15:0] r_cnt,   w_cnt;
    logic [31:0] r_sh,    w_sh;
    logic [31:0] r_crc,   w_crc;
    logic        r_last,  w_last;
    logic        w_txen;
    logic [1:0]  w_txd;
    logic        w_axiir;
    logic        w_xfer;

    // Reflected CRC-32 advanced by one byte, LSB first
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] v;
        v = c;
        for (int unsigned i = 0; i < 8; i++) begin
            v = (v[0] ^ d[i]) ? ((v >> 1) ^ CRC_POLY) : (v >> 1);
        end
        return v;
    endfunction

    assign w_xfer = axiir & axiiv;

    // State, counter, shift register and CRC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_crc   <= '1;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_sh    <= w_sh;
            r_crc   <= w_crc;
            r_last  <= w_last;
        end
    end

    // Next-state logic; r_state always describes the dibit currently on the wire
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt + 16'd1;
        w_sh    = r_sh;
        w_crc   = r_crc;
        w_last  = r_last;
        case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                if (axiiv) begin
                    w_state = S_PRE;
                    w_crc   = '1;
                end
            end
            S_PRE: begin
                if (r_cnt == PRE_LAST) begin
                    w_cnt = '0;
                    if (w_xfer) begin
                        w_state = S_PAY;
                        w_sh    = {24'h0, axiid};
                        w_last  = axiil;
                        w_crc   = crc_byte(r_crc, axiid);
                    end else begin
                        w_state = S_IPG;
                    end
                end
            end
            S_PAY: begin
                w_sh = r_sh >> 2;
                if (r_cnt == 16'd3) begin
                    w_cnt = '0;
                    if (!r_last) begin
                        if (w_xfer) begin
                            w_sh   = {24'h0, axiid};
                            w_last = axiil;
                            w_crc  = crc_byte(r_crc, axiid);
                        end else begin
                            w_state = S_IPG;
                        end
                    end else if (FCS_EN != 0) begin
                        w_state = S_FCS;
                        w_sh    = ~r_crc;
                    end else begin
                        w_state = S_IPG;
                    end
                end
            end
            S_FCS: begin
                w_sh = r_sh >> 2;
                if (r_cnt == 16'd15) begin
                    w_state = S_IPG;
                    w_cnt   = '0;
                end
            end
            S_IPG: begin
                if (r_cnt == IPG_LAST) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
            end
        endcase
    end

    // Output decode from the next state so the pins register alongside it
    always_comb begin
        w_txen  = (w_state == S_PRE) || (w_state == S_PAY) || (w_state == S_FCS);
        w_txd   = 2'b00;
        w_axiir = 1'b0;
        case (w_state)
            S_PRE: begin
                w_txd   = (w_cnt == PRE_LAST) ? 2'b11 : 2'b01;
                w_axiir = (w_cnt == PRE_LAST);
            end
            S_PAY: begin
                w_txd   = w_sh[1:0];
                w_axiir = (w_cnt == 16'd3) && !w_last;
            end
            S_FCS:   w_txd = w_sh[1:0];
            default: w_txd = 2'b00;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txen  <= 1'b0;
            txd   <= 2'b00;
            axiir <= 1'b0;
        end else begin
            txen  <= w_txen;
            txd   <= w_txd;
            axiir <= w_axiir;
        end
    end

endmodule

// File: tb/tb_rmii_tx.sv
// Testbench for rmii_tx: randomized frames against a dibit-sequence model.
module tb_rmii_tx;

    localparam int PRE = 7;

    typedef logic [7:0] bq_t[$];
    typedef logic [1:0] dq_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       axiiv = 1'b0;
    logic [7:0] axiid = 8'h00;
    logic       axiil = 1'b0;
    logic       axiir;
    logic       txen;
    logic [1:0] txd;

    logic       v2 = 1'b0;
    logic [7:0] d2 = 8'h00;
    logic       l2 = 1'b0;
    logic       r2;
    logic       en2;
    logic [1:0] txd2;

    int total = 0;
    int bad   = 0;

    // monitor state
    dq_t cap;
    int  flen[$];
    int  gaps[$];
    int  rdy_cnt;
    int  idle_bad;
    int  clr_req = 0;

    rmii_tx #(.PREAMBLE_BYTES(PRE), .IPG_CYCLES(48), .FCS_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid), .axiil(axiil),
        .axiir(axiir), .txen(txen), .txd(txd)
    );

    rmii_tx #(.PREAMBLE_BYTES(PRE), .IPG_CYCLES(48), .FCS_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .axiiv(v2), .axiid(d2), .axiil(l2),
        .axiir(r2), .txen(en2), .txd(txd2)
    );

    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // Wire monitor: records txen-high dibits, frame lengths and low gaps
    initial begin
        int  clr_seen = 0;
        int  run = 0;
        int  low = 0;
        bit  prev = 0;
        bit  seen = 0;
        forever begin
            @(negedge clk);
            if (clr_req != clr_seen) begin
                clr_seen = clr_req;
                cap.delete(); flen.delete(); gaps.delete();
                run = 0; low = 0; prev = 0; seen = 0; rdy_cnt = 0; idle_bad = 0;
            end else if (rst_n) begin
                if (axiir) rdy_cnt++;
                if (txen) begin
                    if (!prev && seen) gaps.push_back(low);
                    cap.push_back(txd);
                    run++;
                    low = 0;
                end else begin
                    if (prev) begin
                        flen.push_back(run);
                        run = 0;
                        seen = 1;
                    end
                    low++;
                    if (txd !== 2'b00) idle_bad++;
                end
                prev = txen;
            end
        end
    end

    function automatic logic [31:0] sw_fcs(bq_t b);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c ^= {24'h0, b[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic dq_t model(bq_t b, bit fcs);
        dq_t q;
        logic [7:0]  x;
        logic [31:0] f;
        for (int i = 0; i < 4 * PRE + 3; i++) q.push_back(2'b01);
        q.push_back(2'b11);
        foreach (b[i]) begin
            x = b[i];
            for (int k = 0; k < 4; k++) begin
                q.push_back(x[1:0]);
                x = x >> 2;
            end
        end
        if (fcs) begin
            f = sw_fcs(b);
            for (int k = 0; k < 16; k++) begin
                q.push_back(f[1:0]);
                f = f >> 2;
            end
        end
        return q;
    endfunction

    function automatic int first_diff(int start, dq_t e, int len);
        for (int i = 0; i < len; i++) begin
            if (start + i >= cap.size() || i >= e.size()) return i;
            if (cap[start + i] !== e[i]) return i;
        end
        return -1;
    endfunction

    function automatic bq_t rand_bytes(int n);
        bq_t b;
        for (int i = 0; i < n; i++) b.push_back(8'($urandom_range(0, 255)));
        return b;
    endfunction

    task automatic clear_mon();
        @(posedge clk); #1;
        clr_req++;
        @(negedge clk);
    endtask

    task automatic drive(input bq_t b, input int drop_at, input bit hold);
        int idx = 0;
        bit xfer;
        bit done = 0;
        axiid = b[0];
        axiil = (b.size() == 1);
        axiiv = 1'b1;
        for (int g = 0; g < 3000 && !done; g++) begin
            @(negedge clk);
            if (drop_at >= 0 && idx == drop_at && axiir) begin
                axiiv = 1'b0;
                done  = 1;
            end else begin
                xfer = axiir && axiiv;
                @(posedge clk); #1;
                if (xfer) begin
                    idx++;
                    if (idx == b.size()) begin
                        axiiv = hold;
                        done  = 1;
                    end else begin
                        axiid = b[idx];
                        axiil = (idx == b.size() - 1);
                    end
                end
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL drive_timeout: got %0d of %0d bytes accepted", idx, b.size());
        end
    endtask

    task automatic wait_frames(input int n, input string name);
        int g = 0;
        while (flen.size() < n && g < 3000) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (flen.size() < n) begin
            bad++;
            $display("FAIL %s_frames: got %0d frames, expected %0d", name, flen.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        total++; if (txen !== 1'b0)  begin bad++; $display("FAIL rst_txen: got %b expected 0", txen); end
        total++; if (txd !== 2'b00)  begin bad++; $display("FAIL rst_txd: got %b expected 00", txd); end
        total++; if (axiir !== 1'b0) begin bad++; $display("FAIL rst_axiir: got %b expected 0", axiir); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_mon();
        repeat (10) @(negedge clk);
        total++;
        if (flen.size() != 0 || cap.size() != 0 || rdy_cnt != 0) begin
            bad++;
            $display("FAIL idle_quiet: got %0d dibits %0d ready cycles, expected 0 0", cap.size(), rdy_cnt);
        end
    endtask

    task automatic test_single();
        bq_t b;
        dq_t e;
        int  d;
        b.push_back(8'hA5);
        e = model(b, 1);
        clear_mon();
        drive(b, -1, 0);
        wait_frames(1, "single");
        d = first_diff(0, e, e.size());
        total++; if (flen.size() < 1 || flen[0] != 52) begin bad++; $display("FAIL single_len: got %0d expected 52", flen.size() ? flen[0] : -1); end
        total++; if (d != -1) begin bad++; $display("FAIL single_dibits: first difference at index %0d", d); end
        total++; if (rdy_cnt != 1) begin bad++; $display("FAIL single_ready: got %0d ready cycles expected 1", rdy_cnt); end
    endtask

    task automatic test_check_string();
        bq_t b;
        dq_t e;
        dq_t f = '{2'b10,2'b01,2'b10,2'b00,2'b01,2'b10,2'b11,2'b00,
                   2'b00,2'b01,2'b11,2'b11,2'b11,2'b10,2'b00,2'b11};
        int  d;
        for (int i = 0; i < 9; i++) b.push_back(8'h31 + 8'(i));
        e = model(b, 1);
        repeat (60) @(posedge clk);
        clear_mon();
        drive(b, -1, 0);
        wait_frames(1, "check");
        d = first_diff(0, e, e.size());
        total++; if (flen.size() < 1 || flen[0] != 84) begin bad++; $display("FAIL check_len: got %0d expected 84", flen.size() ? flen[0] : -1); end
        total++; if (d != -1) begin bad++; $display("FAIL check_dibits: first difference at index %0d", d); end
        d = first_diff(68, f, 16);
        total++; if (d != -1) begin bad++; $display("FAIL check_fcs: FCS dibit %0d differs from known CRC 0xCBF43926", d); end
    endtask

    task automatic test_back_to_back();
        bq_t b1, b2;
        dq_t e1, e2;
        int  d;
        b1 = rand_bytes($urandom_range(1, 6));
        b2 = rand_bytes($urandom_range(1, 6));
        e1 = model(b1, 1);
        e2 = model(b2, 1);
        repeat (60) @(posedge clk);
        clear_mon();
        drive(b1, -1, 1);
        drive(b2, -1, 0);
        wait_frames(2, "b2b");
        if (flen.size() >= 2) begin
            total++; if (flen[0] != e1.size()) begin bad++; $display("FAIL b2b_len1: got %0d expected %0d", flen[0], e1.size()); end
            total++; if (flen[1] != e2.size()) begin bad++; $display("FAIL b2b_len2: got %0d expected %0d", flen[1], e2.size()); end
            d = first_diff(0, e1, e1.size());
            total++; if (d != -1) begin bad++; $display("FAIL b2b_frame1: first difference at index %0d", d); end
            d = first_diff(flen[0], e2, e2.size());
            total++; if (d != -1) begin bad++; $display("FAIL b2b_frame2: first difference at index %0d", d); end
            total++; if (cap[flen[0]] !== 2'b01) begin bad++; $display("FAIL b2b_pre2: got %b expected 01", cap[flen[0]]); end
        end
        total++; if (gaps.size() < 1 || gaps[0] != 49) begin bad++; $display("FAIL b2b_gap: got %0d expected 49", gaps.size() ? gaps[0] : -1); end
        total++; if (idle_bad != 0) begin bad++; $display("FAIL b2b_idle_txd: got %0d nonzero idle dibits expected 0", idle_bad); end
    endtask

    task automatic test_underrun();
        bq_t b, b2;
        dq_t e, e2;
        int  d;
        b  = rand_bytes(5);
        b2 = rand_bytes($urandom_range(1, 4));
        e  = model(b, 1);
        e2 = model(b2, 1);
        repeat (60) @(posedge clk);
        clear_mon();
        drive(b, 2, 0);
        wait_frames(1, "underrun");
        total++; if (flen.size() < 1 || flen[0] != 40) begin bad++; $display("FAIL underrun_len: got %0d expected 40", flen.size() ? flen[0] : -1); end
        d = first_diff(0, e, 40);
        total++; if (d != -1) begin bad++; $display("FAIL underrun_dibits: first difference at index %0d", d); end
        drive(b2, -1, 0);
        wait_frames(2, "underrun_next");
        total++; if (gaps.size() < 1 || gaps[0] != 49) begin bad++; $display("FAIL underrun_gap: got %0d expected 49", gaps.size() ? gaps[0] : -1); end
        if (flen.size() >= 2) begin
            d = first_diff(flen[0], e2, e2.size());
            total++; if (d != -1 || flen[1] != e2.size()) begin bad++; $display("FAIL underrun_next: first difference %0d length %0d expected %0d", d, flen[1], e2.size()); end
        end
    endtask

    task automatic test_async_reset();
        bq_t b;
        dq_t e;
        int  d;
        int  g = 0;
        repeat (60) @(posedge clk);
        axiid = 8'($urandom_range(0, 255));
        axiil = 1'b0;
        axiiv = 1'b1;
        while (!axiir && g < 200) begin
            @(negedge clk);
            g++;
        end
        repeat (6) @(negedge clk);
        total++; if (txen !== 1'b1) begin bad++; $display("FAIL arst_pre_txen: got %b expected 1", txen); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (txen !== 1'b0)  begin bad++; $display("FAIL arst_txen: got %b expected 0", txen); end
        total++; if (txd !== 2'b00)  begin bad++; $display("FAIL arst_txd: got %b expected 00", txd); end
        total++; if (axiir !== 1'b0) begin bad++; $display("FAIL arst_axiir: got %b expected 0", axiir); end
        axiiv = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        b = rand_bytes($urandom_range(2, 6));
        e = model(b, 1);
        clear_mon();
        drive(b, -1, 0);
        wait_frames(1, "arst_after");
        d = first_diff(0, e, e.size());
        total++; if (d != -1 || flen.size() < 1 || flen[0] != e.size()) begin bad++; $display("FAIL arst_after: first difference %0d length %0d expected %0d", d, flen.size() ? flen[0] : -1, e.size()); end
    endtask

    task automatic test_fcs_off();
        bq_t b;
        dq_t e;
        dq_t got;
        logic [7:0] lastb;
        int  idx = 0;
        int  d   = -1;
        bit  xfer;
        bit  ended = 0;
        b = rand_bytes(2);
        e = model(b, 0);
        lastb = b[1];
        d2 = b[0];
        l2 = 1'b0;
        v2 = 1'b1;
        for (int g = 0; g < 300 && !ended; g++) begin
            @(negedge clk);
            if (en2) got.push_back(txd2);
            else if (got.size() > 0) ended = 1;
            xfer = r2 && v2;
            @(posedge clk); #1;
            if (xfer) begin
                idx++;
                if (idx == 2) v2 = 1'b0;
                else begin d2 = b[1]; l2 = 1'b1; end
            end
        end
        total++; if (!ended || got.size() != 40) begin bad++; $display("FAIL nofcs_len: got %0d expected 40", got.size()); end
        for (int i = 0; i < e.size() && i < got.size(); i++)
            if (d == -1 && got[i] !== e[i]) d = i;
        total++; if (d != -1) begin bad++; $display("FAIL nofcs_dibits: first difference at index %0d", d); end
        total++; if (got.size() == 0 || got[got.size() - 1] !== lastb[7:6]) begin bad++; $display("FAIL nofcs_last: got %b expected %b", got.size() ? got[got.size() - 1] : 2'bxx, lastb[7:6]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_check_string();
        test_back_to_back();
        test_underrun();
        test_async_reset();
        test_fcs_off();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rmii_tx.md
Name: rmii_tx

Overview:
- Transmit-side counterpart to the RMII receive chain.
- Accepts a byte-wide frame stream (destination MAC through payload) from the packet builder and serialises it onto the 2-bit RMII TX interface.
- Prepends preamble/SFD, transmits every byte LSB-dibit first, appends the CRC-32 FCS, then enforces the inter-packet gap.
- Output feeds the PHY TXEN/TXD pins directly.

Parameters:
- PREAMBLE_BYTES, 7: number of 0x55 bytes sent before the SFD (0xD5).
- IPG_CYCLES, 48: clock cycles with txen low after each frame (12 bytes × 4 dibits).
- FCS_EN, 1: 1 = append 4-byte FCS; 0 = end the frame after the last payload dibit.

Ports:
- clk  in  1  50 MHz RMII reference clock
- rst_n  in  1  reset, asynchronous, active-low
- axiiv  in  1  upstream byte valid
- axiid  in  8  upstream byte
- axiil  in  1  marks final byte of frame; qualified by axiiv && axiir
- axiir  out  1  ready; a byte transfers on a cycle with axiiv && axiir
- txen  out  1  RMII transmit enable
- txd  out  2  RMII transmit dibit

Behaviour:
- Interface decision: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: while rst_n is low, all outputs are 0 (txen=0, txd=0, axiir=0), state=IDLE, CRC=0xFFFFFFFF, counters cleared. Reset mid-frame truncates the frame immediately; no FCS and no IPG follow.
- Output timing: all outputs are registered. One dibit per cycle while txen=1.
- IDLE:
  - txen=0, axiir=0.
  - axiiv=1 at cycle t → PREAMBLE, with txen=1 at t+1.
  - No upstream byte is consumed at this point.
- PREAMBLE:
  - 4·PREAMBLE_BYTES+4 cycles.
  - txd=01 for all cycles except the last, which sends 11 (SFD 0xD5 LSB-first: 01,01,01,11).
  - axiir=1 on the final SFD cycle.
- PAYLOAD:
  - Accepted byte is loaded into the shift register; dibits go out on the next 4 cycles as d[1:0], d[3:2], d[5:4], d[7:6].
  - axiir=1 only on the 4th dibit cycle of a non-last byte, so transmission is gapless.
  - If axiir=1 and axiiv=0 (underrun), the frame aborts: txen=0 the next cycle, no FCS, go to IPG.
- CRC:
  - Reflected CRC-32: polynomial 0xEDB88320, init 0xFFFFFFFF, updated per accepted payload byte (or per dibit, implementer's choice).
  - FCS = bitwise inverse of the CRC register, sent LSB dibit first: 16 cycles.
  - Preamble and SFD are excluded from the CRC.
- Frame end:
  - When the last byte (axiil=1) finishes its 4th dibit: go to FCS if FCS_EN=1, else to IPG.
  - After the FCS completes: IPG.
  - Total txen-high cycles = 4·(PREAMBLE_BYTES+1) + 4N + 16·FCS_EN.
- IPG:
  - txen=0, txd=00, axiir=0 for exactly IPG_CYCLES, then IDLE.
  - axiiv held high during IPG starts the next frame on the first IDLE cycle.
  - Minimum txen-low gap between frames = IPG_CYCLES+1.
- CRC reinitialises to 0xFFFFFFFF on entry to PREAMBLE.
- No padding to the 60-byte minimum; upstream guarantees frame length.
- txd=00 whenever txen=0.
- axiid and axiil are ignored unless a transfer occurs.

Test Plan:
- Reset then one byte 0xA5 with axiil=1 → txen high for 52 cycles: 31×01, 11, then 01,01,10,10, then 16 FCS dibits matching a software CRC-32 model; axiir pulses exactly once.
- ASCII "123456789" (9 bytes, last on 0x39) with axiiv held high → txen high for 84 cycles; FCS bytes on the wire 0x26,0x39,0xF4,0xCB (dibits 10,01,10,00,01,10,11,00,00,01,11,11,11,10,00,11); no txen bubble between payload and FCS.
- Two frames back-to-back with axiiv held during IPG → txen low for exactly 49 cycles between frames; the second preamble starts with 01 and its FCS is correct (CRC reinitialised).
- Underrun: drop axiiv on the 2nd byte's ready cycle of a 5-byte frame → txen falls the following cycle after 40 high cycles; no FCS; next frame starts no sooner than 49 cycles later.
- Assert rst_n low asynchronously mid-payload → txen, txd, axiir go to 0 without a clock edge; after release, a new frame transmits a full preamble and correct FCS.
- FCS_EN=0 build, 2-byte frame → txen high for exactly 40 cycles, ending on the last payload dibit.
